// File: rtl/uart_tx_unit_pkg.sv
// uart_tx_unit_pkg: shared UART state encodings and default link timing
package uart_tx_unit_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;
  localparam int OS_RATE      = 16;
  localparam int DEF_BAUD_DIV = 326;
  localparam int DEF_NB_DIV   = 9;
  localparam int DEF_SB_TICK  = 16;
endpackage

// File: rtl/uart_tx_unit_baud_gen.sv
// uart_tx_unit_baud_gen: free-running 16x oversampling tick generator, shared with the receiver
module uart_tx_unit_baud_gen
  import uart_tx_unit_pkg::*;
#(
  parameter int M = DEF_BAUD_DIV,
  parameter int N = DEF_NB_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);
  localparam logic [N-1:0] LAST = N'(M - 1);
  logic [N-1:0] r_cnt;
  logic         w_last;
  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;
  // modulo-M counter; the tick is the single clock spent at the top count
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) r_cnt <= '0;
    else          r_cnt <= w_last ? '0 : r_cnt + N'(1);
endmodule

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1/8N1.5/8N2 serial transmitter driven by a 16x baud tick
module uart_tx_unit
  import uart_tx_unit_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = DEF_SB_TICK,
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int NB_DIV   = DEF_NB_DIV
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_tx_data,
  output logic            o_tx,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick,
  output logic            o_s_tick
);
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] OS_LAST = SW'(OS_RATE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  tx_state_e       r_state, w_state;
  logic [SW-1:0]   r_s_cnt, w_s_cnt;
  logic [NW-1:0]   r_n_cnt, w_n_cnt;
  logic [DBIT-1:0] r_b, w_b;
  logic            r_tx, w_tx, w_done, w_s_tick;
  uart_tx_unit_baud_gen #(.M(BAUD_DIV), .N(NB_DIV)) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_s_tick)
  );
  // state, counters, shift register and the glitch-free line flop
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_s_cnt <= w_s_cnt;
      r_n_cnt <= w_n_cnt;
      r_b     <= w_b;
      r_tx    <= w_tx;
    end
  // next-state logic; the line value follows the current state and is registered
  always_comb begin
    w_state = r_state;
    w_s_cnt = r_s_cnt;
    w_n_cnt = r_n_cnt;
    w_b     = r_b;
    w_tx    = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      IDLE:
        if (i_tx_start) begin
          w_state = START;
          w_s_cnt = '0;
          w_b     = i_tx_data;
        end
      START: begin
        w_tx = 1'b0;
        if (w_s_tick) begin
          if (r_s_cnt == OS_LAST) begin
            w_state = DATA;
            w_s_cnt = '0;
            w_n_cnt = '0;
          end else w_s_cnt = r_s_cnt + SW'(1);
        end
      end
      DATA: begin
        w_tx = r_b[0];
        if (w_s_tick) begin
          if (r_s_cnt == OS_LAST) begin
            w_b     = r_b >> 1;
            w_s_cnt = '0;
            if (r_n_cnt == N_LAST) w_state = STOP;
            else w_n_cnt = r_n_cnt + NW'(1);
          end else w_s_cnt = r_s_cnt + SW'(1);
        end
      end
      STOP:
        if (w_s_tick) begin
          if (r_s_cnt == SB_LAST) begin
            w_state = IDLE;
            w_s_cnt = '0;
            w_done  = 1'b1;
          end else w_s_cnt = r_s_cnt + SW'(1);
        end
    endcase
  end
  assign o_tx           = r_tx;
  assign o_tx_busy      = (r_state != IDLE);
  assign o_tx_done_tick = w_done;
  assign o_s_tick       = w_s_tick;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed + random frames checked against a bit-queue model of the 8N1 line
module tb_uart_tx_unit;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx1, busy1, done1, tick1, tx2, busy2, done2, tick2;
  logic       tx, busy, done, stick;
  int         n_assert = 0, n_fail = 0, n_done = 0;
  int         sb_now = 16;
  assign tx    = sel ? tx2   : tx1;
  assign busy  = sel ? busy2 : busy1;
  assign done  = sel ? done2 : done1;
  assign stick = sel ? tick2 : tick1;
  always #5 clk = ~clk;
  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD), .NB_DIV(2)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_tx_start(start), .i_tx_data(data),
    .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done_tick(done1), .o_s_tick(tick1));
  uart_tx_unit #(.DBIT(8), .SB_TICK(32), .BAUD_DIV(BD), .NB_DIV(2)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_tx_start(start), .i_tx_data(data),
    .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done_tick(done2), .o_s_tick(tick2));
  always @(negedge clk) if (done === 1'b1) n_done++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_fall();
    int i;
    for (i = 0; i < 400 && tx !== 1'b0; i++) step();
    chk("start_edge", tx === 1'b0, 1);
  endtask
  // entered on the first low sample of the start bit; returns one clock after the done pulse
  task automatic check_frame(input logic [7:0] d);
    logic       exp_q[$];
    logic [7:0] got;
    int         busy_low, run, j;
    exp_q = {1'b0};
    for (int i = 0; i < 8; i++) exp_q.push_back(((d >> i) & 8'h01) != 0);
    exp_q.push_back(1'b1);
    busy_low = 0;
    run = 0;
    got = 8'h00;
    for (int k = 0; k < 9; k++) begin
      step(k == 0 ? BIT / 2 : BIT);
      if (busy !== 1'b1) busy_low++;
      chk($sformatf("bit%0d_of_%02h", k, d), tx, exp_q[k]);
      if (k > 0) got[k-1] = tx;
    end
    for (j = 1; j <= sb_now * BD + 64 && done !== 1'b1; j++) begin
      step();
      if (busy !== 1'b1) busy_low++;
      run = (tx === 1'b1) ? run + 1 : 0;
      if (j == BIT) chk($sformatf("stop_of_%02h", d), tx, exp_q[9]);
    end
    chk("decode", got, d);
    chk("done_seen", done, 1);
    chk("busy_hold", busy_low, 0);
    if (!d[7]) chk("stop_len", run >= sb_now * BD - 1 && run <= sb_now * BD, 1);
    step();
    chk("busy_fall", busy, 0);
    chk("idle_line", tx, 1);
  endtask
  task automatic do_frame(input logic [7:0] d);
    int b;
    b = n_done;
    data = d;
    start = 1'b1;
    step();
    start = 1'b0;
    data = 8'($urandom);
    wait_fall();
    check_frame(d);
    chk("one_done", n_done - b, 1);
  endtask
  initial begin
    int ticks, bad, b, g;
    step(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", stick, 0);
    rst_n = 1'b1;
    ticks = 0;
    bad = 0;
    repeat (1000) begin
      step();
      ticks += int'(stick);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("tick_rate", ticks, 1000 / BD);
    chk("idle_quiet", bad, 0);
    do_frame(8'hA5);
    b = n_done;
    data = 8'h6E;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_fall();
    fork
      begin
        step(300);
        data = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
      end
    join_none
    check_frame(8'h6E);
    bad = 0;
    repeat (200) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("drop_midframe", bad, 0);
    chk("drop_one_done", n_done - b, 1);
    b = n_done;
    data = 8'h05;
    start = 1'b1;
    step();
    wait_fall();
    check_frame(8'h05);
    g = 0;
    while (tx === 1'b1 && g < 50) begin
      g++;
      step();
    end
    chk("b2b_gap", g >= 1 && g <= BD + 2, 1);
    start = 1'b0;
    check_frame(8'h05);
    chk("b2b_done", n_done - b, 2);
    step(100);
    chk("b2b_stop", busy, 0);
    b = n_done;
    data = 8'h3C;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_fall();
    step(BIT / 2 + 4 * BIT);
    chk("bit3_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    step(5);
    chk("abort_no_done", n_done - b, 0);
    rst_n = 1'b1;
    step(3);
    do_frame(8'h81);
    repeat (3) begin
      step($urandom_range(0, 20));
      do_frame(8'($urandom));
    end
    rst_n = 1'b0;
    step(2);
    sel = 1'b1;
    sb_now = 32;
    rst_n = 1'b1;
    step(5);
    do_frame(8'h00);
    do_frame(8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
